// File: rtl/axi_lite_csr_regs_if.sv
// AXI-lite style CSR bus: independent write address / write data channels,
// a 2-bit write response code, and a single-outstanding read channel.
interface axi_lite_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  wavalid;
    logic                  waready;
    logic [ADDR_WIDTH-1:0] waddr;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bdata;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;

    modport slave (
        input  wavalid, waddr, wvalid, wdata, bready, arvalid, araddr, rready,
        output waready, wready, bvalid, bdata, arready, rvalid, rdata
    );
    modport master (
        output wavalid, waddr, wvalid, wdata, bready, arvalid, araddr, rready,
        input  waready, wready, bvalid, bdata, arready, rvalid, rdata
    );
endinterface

// File: rtl/axi_lite_csr_regs.sv
// AXI-lite CSR bank: NUM_RW control registers followed by NUM_RO status words.
// Write address/data are held independently until both are present, then committed.

module axi_lite_csr_rw_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  gclk_i,
    input  logic                  grst_ni,
    input  logic                  we_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  pulse_o
);
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  pulse_q;

    assign q_d = we_i ? wdata_i : q_q;

    always_ff @(posedge gclk_i) begin
        if (!grst_ni) begin
            q_q     <= '0;
            pulse_q <= 1'b0;
        end else begin
            q_q     <= q_d;
            pulse_q <= we_i;
        end
    end

    assign q_o     = q_q;
    assign pulse_o = pulse_q;
endmodule

module axi_lite_csr_regs #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_RW     = 4,
    parameter int NUM_RO     = 4
) (
    input  logic                         gclk_i,
    input  logic                         grst_ni,
    axi_lite_if.slave                    s,
    output logic [NUM_RW*DATA_WIDTH-1:0] rw_regs_o,
    output logic [NUM_RW-1:0]            rw_wr_pulse_o,
    input  logic [NUM_RO*DATA_WIDTH-1:0] ro_regs_i
);
    localparam int IDX_W    = ADDR_WIDTH - 2;
    localparam int NUM_REGS = NUM_RW + NUM_RO;
    localparam logic [IDX_W:0] RW_LIM  = (IDX_W+1)'(NUM_RW);
    localparam logic [IDX_W:0] ALL_LIM = (IDX_W+1)'(NUM_REGS);

    generate
        if (NUM_REGS > 2**IDX_W) begin : g_map_overflow
            $error("axi_lite_csr_regs: NUM_RW+NUM_RO exceeds the address map");
        end
    endgenerate

    logic                  aw_held_q, aw_held_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bdata_q, bdata_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [NUM_RW-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_RO-1:0][DATA_WIDTH-1:0] ro;
    logic [NUM_RW-1:0]                 we;

    logic                  waready, wready, arready;
    logic                  aw_fire, w_fire, ar_fire, commit;
    logic [IDX_W-1:0]      c_idx, ar_idx;
    logic [DATA_WIDTH-1:0] c_data, rd_mux;
    logic [1:0]            c_code;
    logic                  unused_addr_lsbs;

    assign ro               = ro_regs_i;
    assign unused_addr_lsbs = ^{s.waddr[1:0], s.araddr[1:0]};

    // Readies come from internal flags only, never from the *valid inputs.
    assign waready = !aw_held_q && !bvalid_q;
    assign wready  = !w_held_q && !bvalid_q;
    assign arready = !rvalid_q;

    assign aw_fire = s.wavalid && waready;
    assign w_fire  = s.wvalid && wready;
    assign ar_fire = s.arvalid && arready;
    assign commit  = (aw_held_q || aw_fire) && (w_held_q || w_fire);

    assign c_idx  = aw_held_q ? aw_idx_q : s.waddr[ADDR_WIDTH-1:2];
    assign c_data = w_held_q ? w_data_q : s.wdata;
    assign ar_idx = s.araddr[ADDR_WIDTH-1:2];

    always_comb begin
        if ({1'b0, c_idx} < RW_LIM)       c_code = 2'd0;
        else if ({1'b0, c_idx} < ALL_LIM) c_code = 2'd1;
        else                              c_code = 2'd2;
    end

    // Read mux sees pre-commit register values, so a same-edge write is not visible.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_RW; i++)
            if (ar_idx == IDX_W'(i)) rd_mux = regs[i];
        for (int j = 0; j < NUM_RO; j++)
            if (ar_idx == IDX_W'(NUM_RW + j)) rd_mux = ro[j];
    end

    always_comb begin
        aw_held_d = commit ? 1'b0 : (aw_fire ? 1'b1 : aw_held_q);
        aw_idx_d  = aw_fire ? s.waddr[ADDR_WIDTH-1:2] : aw_idx_q;
        w_held_d  = commit ? 1'b0 : (w_fire ? 1'b1 : w_held_q);
        w_data_d  = w_fire ? s.wdata : w_data_q;
        bvalid_d  = commit ? 1'b1 : ((bvalid_q && s.bready) ? 1'b0 : bvalid_q);
        bdata_d   = commit ? c_code : bdata_q;
        rvalid_d  = ar_fire ? 1'b1 : ((rvalid_q && s.rready) ? 1'b0 : rvalid_q);
        rdata_d   = ar_fire ? rd_mux : rdata_q;
    end

    always_ff @(posedge gclk_i) begin
        if (!grst_ni) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            bvalid_q  <= 1'b0;
            bdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            bvalid_q  <= bvalid_d;
            bdata_q   <= bdata_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    generate
        for (genvar g = 0; g < NUM_RW; g++) begin : g_rw
            assign we[g] = commit && (c_idx == IDX_W'(g));
            axi_lite_csr_rw_reg #(.DATA_WIDTH(DATA_WIDTH)) u_reg (
                .gclk_i  (gclk_i),
                .grst_ni (grst_ni),
                .we_i    (we[g]),
                .wdata_i (c_data),
                .q_o     (regs[g]),
                .pulse_o (rw_wr_pulse_o[g])
            );
        end
    endgenerate

    assign rw_regs_o = regs;
    assign s.waready = waready;
    assign s.wready  = wready;
    assign s.arready = arready;
    assign s.bvalid  = bvalid_q;
    assign s.bdata   = bdata_q;
    assign s.rvalid  = rvalid_q;
    assign s.rdata   = rdata_q;
endmodule
